boot_sequencer: RTL and testbench
=================================

# boot_sequencer

Multi-channel power-up and boot sequencer for the external modules on the sensor board (ESP, radio, sensor hubs). It generalises the single-ESP boot wait to NUM_CHANNELS channels. Per channel it provides:
- staggered enable release
- a boot-wait timer
- an output-enable for tristate gating of that module's bus
- per-channel restart
- an optional heartbeat watchdog with sticky fault

It sits at the top level between the board reset button logic and the tristate pad assignments.

## Interface
- NUM_CHANNELS, 4: number of sequenced modules (1..16)
- BOOT_CYCLES, 16_000_000: cycles from en rising to ready rising (>=1)
- STAGGER_CYCLES, 1600: spacing between successive channels' initial enable (>=1)
- OFF_CYCLES, 16000: cycles en is held low on a restart (>=1)
- WATCHDOG_CYCLES, 0: heartbeat timeout in cycles while ready; 0 disables the watchdog
- CNT_WIDTH, 32: width of all internal counters; must hold every cycle parameter above
- clk  in  1  system clock (16 MHz board clock)
- rst  in  1  asynchronous, active-high reset
- restart  in  NUM_CHANNELS  per-channel single-cycle restart request
- heartbeat  in  NUM_CHANNELS  asynchronous per-channel alive signal; any toggle counts as alive
- clear_fault  in  1  single-cycle pulse that clears all fault bits
- en  out  NUM_CHANNELS  module enable (drives ESP_EN-style pins)
- ready  out  NUM_CHANNELS  module booted; also the output-enable for that module's tristate pads
- fault  out  NUM_CHANNELS  sticky watchdog-timeout flag
- all_ready  out  1  AND of ready (combinational from registers)

## Operation
- All outputs are registered except all_ready. During rst: en=0, ready=0, fault=0, all counters 0, every channel in WAIT_SLOT.
- Global slot counter: counts up from 0 after reset release. It saturates once the last channel has been released and is never restarted except by rst.
- Per-channel states:
  - WAIT_SLOT: en=0, ready=0. Channel i leaves when the slot counter equals i*STAGGER_CYCLES and goes to BOOT.
  - BOOT: en=1, ready=0. The boot timer counts to BOOT_CYCLES, then the channel goes to READY.
  - READY: en=1, ready=1. The watchdog runs here if enabled.
  - OFF: en=0, ready=0. The off timer counts to OFF_CYCLES, then the channel goes to BOOT. The boot timer restarts from 0.
- restart[i] behaviour by state:
  - In BOOT or READY: go to OFF.
  - In OFF: reload the off timer to 0, extending the hold.
  - In WAIT_SLOT: ignored.
- Heartbeat path: 2-flop synchroniser plus a delay flop; an edge is sync != delayed.
- Watchdog counter:
  - Cleared on entry to READY and on each detected edge.
  - Otherwise increments in READY.
  - On reaching WATCHDOG_CYCLES: set fault[i] and go to OFF.
  - Heartbeat is ignored outside READY.
- Simultaneous events:
  - Watchdog timeout and restart in the same cycle: go to OFF, and fault is still set.
  - clear_fault and a timeout on the same channel in the same cycle: fault ends set.
- Channels are fully independent after their slot release.

## Timing
Edge n is the n-th rising clk edge with rst low.
- Cold boot:
  - en[i] rises after edge i*STAGGER_CYCLES+1.
  - ready[i] rises after edge i*STAGGER_CYCLES+1+BOOT_CYCLES.
- restart[i] sampled high at edge k while in BOOT or READY:
  - en[i] and ready[i] fall after edge k.
  - en[i] rises after edge k+OFF_CYCLES.
  - ready[i] rises after edge k+OFF_CYCLES+BOOT_CYCLES.
- Heartbeat toggle at the pin: an edge is detected 3 edges later, so watchdog clear latency is 3 cycles.
- Watchdog, with ready[i] rising after edge r and no detected edge: fault[i] rises and ready[i]/en[i] fall after edge r+WATCHDOG_CYCLES.
- rst asserted at any time, including mid-boot: outputs are 0 immediately (asynchronously). After release, the sequence restarts from edge 1.

## Test plan
Bench parameters: NUM_CHANNELS=3, BOOT_CYCLES=10, STAGGER_CYCLES=4, OFF_CYCLES=5, WATCHDOG_CYCLES=8.
1. Hold rst for 5 cycles -> en=000, ready=000, fault=000, all_ready=0 throughout, including asynchronous clear mid-cycle.
2. Cold boot:
   - en[0] rises after edge 1, en[1] after edge 5, en[2] after edge 9.
   - ready[0] rises after edge 11, ready[1] after edge 15, ready[2] after edge 19.
   - all_ready rises with ready[2].
3. restart[1] pulse at edge 30 -> en[1] and ready[1] low after edge 30; en[1] high after edge 35; ready[1] high after edge 45. Channels 0 and 2 are unaffected.
4. Second restart[1] pulse at edge 33, during the OFF hold -> en[1] rises after edge 38 instead of 35.
5. Toggle heartbeat[0] every 4 cycles and hold heartbeat[2] constant after ready[2] rises at edge 19:
   - fault[2]=1 and ready[2]=0 after edge 27; ready[2] returns after edge 42.
   - Channel 0 stays ready, and fault[0]=0.
   - clear_fault then clears fault[2].
6. Assert rst at edge 13, mid-boot of channel 1 -> all outputs 0 at once. After release, the timing of scenario 2 repeats exactly.

Source files
------------

// File: rtl/boot_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : boot_sequencer                                         |
// | Description : Multi-channel power-up / boot sequencer. Staggers the  |
// |               enable of each external module, waits a boot time,     |
// |               then raises ready (tristate output-enable). Supports   |
// |               per-channel restart and an optional heartbeat watchdog |
// |               with a sticky fault flag.                              |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module boot_sequencer #(
  parameter int NUM_CHANNELS    = 4,
  parameter int BOOT_CYCLES     = 16_000_000,
  parameter int STAGGER_CYCLES  = 1600,
  parameter int OFF_CYCLES      = 16000,
  parameter int WATCHDOG_CYCLES = 0,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CHANNELS-1:0] restart,
  input  logic [NUM_CHANNELS-1:0] heartbeat,
  input  logic                    clear_fault,
  output logic [NUM_CHANNELS-1:0] en,
  output logic [NUM_CHANNELS-1:0] ready,
  output logic [NUM_CHANNELS-1:0] fault,
  output logic                    all_ready
);

  typedef enum logic [1:0] {
    ST_WAIT_SLOT = 2'd0,
    ST_BOOT      = 2'd1,
    ST_READY     = 2'd2,
    ST_OFF       = 2'd3
  } chan_state_t;

  // Terminal counts are "value - 1" because each timer starts at 0 on entry.
  localparam logic [CNT_WIDTH-1:0] c_SLOT_LAST =
    CNT_WIDTH'((NUM_CHANNELS - 1) * STAGGER_CYCLES);
  localparam logic [CNT_WIDTH-1:0] c_BOOT_LAST = CNT_WIDTH'(BOOT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] c_OFF_LAST  = CNT_WIDTH'(OFF_CYCLES - 1);
  localparam logic                 c_WD_EN     = (WATCHDOG_CYCLES != 0);
  localparam logic [CNT_WIDTH-1:0] c_WD_LAST   =
    CNT_WIDTH'((WATCHDOG_CYCLES == 0) ? 0 : WATCHDOG_CYCLES - 1);

  logic [CNT_WIDTH-1:0]    r_slot;
  logic [NUM_CHANNELS-1:0] r_hb_s1;
  logic [NUM_CHANNELS-1:0] r_hb_s2;
  logic [NUM_CHANNELS-1:0] r_hb_dly;
  logic [NUM_CHANNELS-1:0] r_en;
  logic [NUM_CHANNELS-1:0] r_ready;
  logic [NUM_CHANNELS-1:0] r_fault;

  // Global slot counter: runs once after reset and parks on the last slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot <= '0;
    end else if (r_slot != c_SLOT_LAST) begin
      r_slot <= r_slot + 1'b1;
    end
  end

  // Heartbeat synchroniser plus delay flop for toggle detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hb_s1  <= '0;
      r_hb_s2  <= '0;
      r_hb_dly <= '0;
    end else begin
      r_hb_s1  <= heartbeat;
      r_hb_s2  <= r_hb_s1;
      r_hb_dly <= r_hb_s2;
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_CHANNELS; g++) begin : g_chan
      localparam logic [CNT_WIDTH-1:0] c_SLOT = CNT_WIDTH'(g * STAGGER_CYCLES);

      chan_state_t          r_state;
      chan_state_t          w_state_nxt;
      logic [CNT_WIDTH-1:0] r_timer;
      logic [CNT_WIDTH-1:0] w_timer_nxt;
      logic [CNT_WIDTH-1:0] r_wd;
      logic [CNT_WIDTH-1:0] w_wd_nxt;
      logic                 w_timeout;
      logic                 w_hb_edge;

      assign w_hb_edge = r_hb_s2[g] ^ r_hb_dly[g];

      // Next-state logic; one timer serves both the boot wait and off hold.
      always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_wd_nxt    = r_wd;
        w_timeout   = 1'b0;
        case (r_state)
          ST_WAIT_SLOT: begin
            if (r_slot == c_SLOT) begin
              w_state_nxt = ST_BOOT;
              w_timer_nxt = '0;
            end
          end
          ST_BOOT: begin
            if (restart[g]) begin
              w_state_nxt = ST_OFF;
              w_timer_nxt = '0;
            end else if (r_timer == c_BOOT_LAST) begin
              w_state_nxt = ST_READY;
              w_wd_nxt    = '0;
            end else begin
              w_timer_nxt = r_timer + 1'b1;
            end
          end
          ST_READY: begin
            if (c_WD_EN) begin
              if (w_hb_edge) begin
                w_wd_nxt = '0;
              end else if (r_wd == c_WD_LAST) begin
                w_timeout = 1'b1;
              end else begin
                w_wd_nxt = r_wd + 1'b1;
              end
            end
            if (restart[g] || w_timeout) begin
              w_state_nxt = ST_OFF;
              w_timer_nxt = '0;
            end
          end
          ST_OFF: begin
            if (restart[g]) begin
              w_timer_nxt = '0;
            end else if (r_timer == c_OFF_LAST) begin
              w_state_nxt = ST_BOOT;
              w_timer_nxt = '0;
            end else begin
              w_timer_nxt = r_timer + 1'b1;
            end
          end
          default: w_state_nxt = ST_WAIT_SLOT;
        endcase
      end

      // State, counters and registered outputs; a timeout beats clear_fault.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_state    <= ST_WAIT_SLOT;
          r_timer    <= '0;
          r_wd       <= '0;
          r_en[g]    <= 1'b0;
          r_ready[g] <= 1'b0;
          r_fault[g] <= 1'b0;
        end else begin
          r_state    <= w_state_nxt;
          r_timer    <= w_timer_nxt;
          r_wd       <= w_wd_nxt;
          r_en[g]    <= (w_state_nxt == ST_BOOT) || (w_state_nxt == ST_READY);
          r_ready[g] <= (w_state_nxt == ST_READY);
          r_fault[g] <= (r_fault[g] & ~clear_fault) | w_timeout;
        end
      end
    end
  endgenerate

  assign en        = r_en;
  assign ready     = r_ready;
  assign fault     = r_fault;
  assign all_ready = &r_ready;

endmodule
`default_nettype wire

// File: tb/tb_boot_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_boot_sequencer                                      |
// | Description : Self-checking bench for boot_sequencer. Expected       |
// |               outputs per clock edge come from the documented        |
// |               timeline and are queued, then compared after the edge. |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tb_boot_sequencer;

  localparam int c_N    = 3;
  localparam int c_BOOT = 10;
  localparam int c_STAG = 4;
  localparam int c_OFF  = 5;
  localparam int c_WD   = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [c_N-1:0] restart = '0;
  logic [c_N-1:0] heartbeat = '0;
  logic           clear_fault = 1'b0;
  logic [c_N-1:0] en;
  logic [c_N-1:0] ready;
  logic [c_N-1:0] fault;
  logic           all_ready;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int         edge_n;
    logic [9:0] val;
  } exp_t;

  exp_t sb[$];

  boot_sequencer #(
    .NUM_CHANNELS   (c_N),
    .BOOT_CYCLES    (c_BOOT),
    .STAGGER_CYCLES (c_STAG),
    .OFF_CYCLES     (c_OFF),
    .WATCHDOG_CYCLES(c_WD),
    .CNT_WIDTH      (32)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .restart    (restart),
    .heartbeat  (heartbeat),
    .clear_fault(clear_fault),
    .en         (en),
    .ready      (ready),
    .fault      (fault),
    .all_ready  (all_ready)
  );

  always #5 clk = ~clk;

  // Count one comparison and report it when the observed value differs.
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h  {all_ready,fault,ready,en}", tag, act, exp);
    end
  endtask

  // Expected {all_ready, fault, ready, en} after edge n of the stimulus
  // timeline: restart[1] at edges 30 and 33, heartbeat[2] never toggles,
  // clear_fault at edge 45.
  function automatic logic [9:0] expect_at(int n);
    logic [2:0] e;
    logic [2:0] r;
    logic [2:0] f;
    e[0] = (n >= 1);
    r[0] = (n >= 11);
    e[1] = (n >= 5)  && !(n >= 30 && n < 38);
    r[1] = (n >= 15) && !(n >= 30 && n < 48);
    e[2] = (n >= 9)  && !(n >= 27 && n < 32);
    r[2] = (n >= 19) && !(n >= 27 && n < 42);
    f    = {(n >= 27 && n < 45), 2'b00};
    return {&r, f, r, e};
  endfunction

  function automatic logic [9:0] observed();
    return {all_ready, fault, ready, en};
  endfunction

  // Drive edges 1..last (entered and left at a falling edge).
  task automatic run_edges(input int last);
    exp_t e;
    for (int n = 1; n <= last; n++) begin
      restart     = (n == 30 || n == 33) ? 3'b010 : 3'b000;
      clear_fault = (n == 45);
      if (n % 4 == 0) heartbeat[1:0] = ~heartbeat[1:0];
      sb.push_back('{n, expect_at(n)});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check($sformatf("edge%0d", e.edge_n), 32'(observed()), 32'(e.val));
      @(negedge clk);
    end
    restart     = '0;
    clear_fault = 1'b0;
  endtask

  initial begin
    // Asynchronous clear in the middle of a cycle, then held reset.
    #3 rst = 1'b1;
    #1 check("async_rst", 32'(observed()), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 check($sformatf("rst_hold%0d", i), 32'(observed()), 32'd0);
    end
    @(negedge clk) rst = 1'b0;

    // Cold boot, restarts, watchdog fault and fault clear.
    run_edges(48);

    // Fresh boot, then reset mid-boot of channel 1 and a full repeat.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_edges(12);
    #2 rst = 1'b1;
    #1 check("midboot_rst", 32'(observed()), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 check($sformatf("midboot_hold%0d", i), 32'(observed()), 32'd0);
    end
    @(negedge clk) rst = 1'b0;
    run_edges(22);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
